// File: rtl/seq_accum_fire_pkg.sv
// Shared types and arithmetic for the sequential synaptic accumulator.
// sat_add works at a fixed maximum width; constant sw/sat_en fold away in synthesis.
package seq_accum_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} acc_state_t;

  localparam int MAX_SW = 32;

  // Returns {ovf, sum}; ovf is the carry out of the low sw bits of the exact sum.
  function automatic logic [MAX_SW:0] sat_add(
    input logic [MAX_SW-1:0] a,
    input logic [MAX_SW-1:0] b,
    input int                sw,
    input logic              sat_en
  );
    logic [MAX_SW:0] exact;
    logic [MAX_SW:0] mask;
    logic [MAX_SW:0] res;
    logic            ovf;
    exact = {1'b0, a} + {1'b0, b};
    mask  = ({{MAX_SW{1'b0}}, 1'b1} << sw) - {{MAX_SW{1'b0}}, 1'b1};
    ovf   = |(exact >> sw);
    res   = ovf ? (sat_en ? mask : (exact & mask)) : exact;
    return {ovf, res[MAX_SW-1:0]};
  endfunction

endpackage

// File: rtl/seq_accum_fire_if.sv
// Control / data bundle between the neuron datapath and the accumulator.
// Handshake: a beat transfers on a rising CK edge where IN_VALID && IN_READY; IN_READY is
// decoded from registered state only, so it never depends on IN_VALID in the same cycle.
interface seq_accum_fire_if
  import seq_accum_pkg::*;
#(
  parameter int W  = 10,
  parameter int SW = 14,
  parameter int CW = 4
);
  logic          START;
  logic          IN_VALID;
  logic [W-1:0]  IN_DATA;
  logic          IN_READY;
  logic [SW-1:0] THRESH;
  logic [SW-1:0] SUM;
  logic [CW-1:0] CNT;
  logic          BUSY;
  logic          DONE;
  logic          FIRE;
  logic          OVF;
  acc_state_t    dbg_state;

  modport master (
    output START, IN_VALID, IN_DATA, THRESH,
    input  IN_READY, SUM, CNT, BUSY, DONE, FIRE, OVF, dbg_state
  );

  modport slave (
    input  START, IN_VALID, IN_DATA, THRESH,
    output IN_READY, SUM, CNT, BUSY, DONE, FIRE, OVF, dbg_state
  );
endinterface

// File: rtl/seq_accum_fire_alu.sv
// Combinational accumulate step: acc + zero-extended din, saturating or wrapping at SW bits.
module accum_alu
  import seq_accum_pkg::*;
#(
  parameter int W      = 10,
  parameter int SW     = 14,
  parameter int SAT_EN = 1
) (
  input  logic [SW-1:0] acc,
  input  logic [W-1:0]  din,
  output logic [SW-1:0] sum,
  output logic          ovf
);
  logic [MAX_SW-1:0] a_ext;
  logic [MAX_SW-1:0] b_ext;
  logic [MAX_SW:0]   res;
  logic              unused_res;

  always_comb begin
    a_ext          = '0;
    b_ext          = '0;
    a_ext[SW-1:0]  = acc;
    b_ext[W-1:0]   = din;
    res            = sat_add(a_ext, b_ext, SW, SAT_EN != 0);
  end

  assign sum        = res[SW-1:0];
  assign ovf        = res[MAX_SW];
  assign unused_res = ^res;
endmodule

// File: rtl/seq_accum_fire.sv
// Sequential synaptic accumulator: sums NUM_IN handshaked beats, then flags FIRE
// when the final sum reaches THRESH. Holds the FSM, beat counter and result registers.
module seq_accum_fire
  import seq_accum_pkg::*;
#(
  parameter int W      = 10,
  parameter int NUM_IN = 10,
  parameter int SW     = 14,
  parameter int SAT_EN = 1
) (
  input logic           CK,
  input logic           RSTB,
  seq_accum_fire_if.slave bus
);
  localparam int CW = $clog2(NUM_IN + 1);

  acc_state_t    state_q, state_d;
  logic [SW-1:0] sum_q;
  logic [CW-1:0] cnt_q;
  logic          fire_q;
  logic          ovf_q;
  logic [SW-1:0] alu_sum;
  logic          alu_ovf;
  logic          beat;
  logic          last_beat;
  logic          start_run;

  accum_alu #(.W(W), .SW(SW), .SAT_EN(SAT_EN)) u_alu (
    .acc (sum_q),
    .din (bus.IN_DATA),
    .sum (alu_sum),
    .ovf (alu_ovf)
  );

  always_comb begin
    state_d   = state_q;
    beat      = 1'b0;
    last_beat = 1'b0;
    start_run = 1'b0;
    case (state_q)
      // DONE accepts START exactly like IDLE so runs can go back to back.
      S_IDLE, S_DONE: begin
        if (bus.START) begin
          start_run = 1'b1;
          state_d   = S_ACC;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_ACC: begin
        beat      = bus.IN_VALID;
        last_beat = beat && (cnt_q == CW'(NUM_IN - 1));
        if (last_beat) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= S_IDLE;
      sum_q   <= '0;
      cnt_q   <= '0;
      fire_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_run) begin
        sum_q  <= '0;
        cnt_q  <= '0;
        fire_q <= 1'b0;
        ovf_q  <= 1'b0;
      end else if (beat) begin
        sum_q <= alu_sum;
        cnt_q <= cnt_q + 1'b1;
        if (alu_ovf) ovf_q <= 1'b1;
        // THRESH matters only on the final beat; FIRE is frozen afterwards.
        if (last_beat) fire_q <= (alu_sum >= bus.THRESH);
      end
    end
  end

  assign bus.IN_READY  = (state_q == S_ACC);
  assign bus.BUSY      = (state_q == S_ACC);
  assign bus.DONE      = (state_q == S_DONE);
  assign bus.SUM       = sum_q;
  assign bus.CNT       = cnt_q;
  assign bus.FIRE      = fire_q;
  assign bus.OVF       = ovf_q;
  assign bus.dbg_state = state_q;
endmodule
